// File: rtl/digit_serial_mul.sv
// Digit-serial unsigned multiplier: N-bit a*b using 2-bit digits, one digit pair per cycle.
// Optional macro DIGIT_SERIAL_MUL_ZERO_BYPASS_EN skips the digit loop when an operand is zero.

module mul_2_bits (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic [3:0] p
);
    assign p = {2'b00, x} * {2'b00, y};
endmodule

module digit_serial_mul #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] c
);
    localparam int D  = N / 2;
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam logic [IW-1:0] LAST = IW'(D - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]     state;
    logic [N-1:0]   a_r;
    logic [N-1:0]   b_r;
    logic [2*N-1:0] acc;
    logic [IW-1:0]  i;
    logic [IW-1:0]  j;

    logic [1:0]     digit_a;
    logic [1:0]     digit_b;
    logic [3:0]     prod;
    logic [2*N-1:0] partial;
    logic [2*N-1:0] acc_next;

    assign in_ready = (state == IDLE);

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        digit_a  = a_r[2*int'(i) +: 2];
        digit_b  = b_r[2*int'(j) +: 2];
        partial  = (2*N)'(prod) << (2 * (int'(i) + int'(j)));
        acc_next = acc + partial;
    end

    mul_2_bits u_mul (
        .x (digit_a),
        .y (digit_b),
        .p (prod)
    );

    // The product of two N-bit values fits in 2N bits, so the accumulator carries nothing out.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            acc       <= '0;
            i         <= '0;
            j         <= '0;
            c         <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r <= a;
                        b_r <= b;
                        acc <= '0;
                        i   <= '0;
                        j   <= '0;
`ifdef DIGIT_SERIAL_MUL_ZERO_BYPASS_EN
                        if ((a == '0) || (b == '0)) begin
                            c         <= '0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= BUSY;
                        end
`else
                        state <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    if (j == LAST) begin
                        j <= '0;
                        if (i == LAST) begin
                            i         <= '0;
                            c         <= acc_next;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            i <= i + IW'(1);
                        end
                    end else begin
                        j <= j + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/digit_serial_mul.md
DIGIT_SERIAL_MUL -- requirements
Module: digit_serial_mul

Interface
REQ-001 SHALL have parameter: N, 4, operand width in bits; even, >= 2; D = N/2 digits per operand.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operand pair a, b presented.
REQ-005 SHALL have port: in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have port: a  input  N  left operand, unsigned.
REQ-007 SHALL have port: b  input  N  right operand, unsigned.
REQ-008 SHALL have port: out_valid  output  1  product c valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts c this cycle.
REQ-010 SHALL have port: c  output  2N  unsigned product a*b.

Function
REQ-011 SHALL use a three-state FSM: IDLE, BUSY, DONE.
REQ-012 SHALL drive in_ready = 1 iff state is IDLE (combinational from state); c and out_valid SHALL be registered.
REQ-013 SHALL, in IDLE with in_valid=1, register a and b, clear the 2N-bit accumulator, set digit indices i=j=0, and enter BUSY.
REQ-014 SHALL, in IDLE with in_valid=0, remain in IDLE with no state change.
REQ-015 SHALL, each BUSY cycle, add the 4-bit product of digit a[2i+1:2i] and digit b[2j+1:2j] (produced by the existing mul_2_bits block), shifted left by 2(i+j), into the accumulator.
REQ-016 SHALL advance j each BUSY cycle; on j = D-1, wrap j to 0 and increment i.
REQ-017 SHALL, on the BUSY cycle with i = j = D-1, load c with the final accumulator value, set out_valid=1, and enter DONE; BUSY SHALL last exactly D*D cycles.
REQ-018 SHALL hold the accumulator at 2N bits; no carry beyond bit 2N-1 can occur, so none is kept.
REQ-019 SHALL, in DONE, hold c and out_valid=1 stable while out_ready=0.
REQ-020 SHALL, in DONE with out_ready=1, clear out_valid and return to IDLE; the next operand pair can be accepted no earlier than the following cycle.
REQ-021 SHALL ignore in_valid, a and b while in BUSY or DONE; registered operands SHALL NOT change.
REQ-022 SHALL keep c at its last product value after the handshake until the next product is loaded.
REQ-023 SHALL make input-accept-to-out_valid latency D*D + 1 rising edges, counting the accept edge.

Reset
REQ-024 SHALL, with rst=1 at a rising edge, force state=IDLE, out_valid=0, c=0, accumulator=0, i=j=0, and registered operands=0.
REQ-025 SHALL give rst priority over every other input, including mid-BUSY and mid-DONE; the operation in flight SHALL be discarded with no output produced.
REQ-026 SHALL present in_ready=1 on the first cycle after reset.

Configuration
REQ-027 SHALL support macro DIGIT_SERIAL_MUL_ZERO_BYPASS_EN.
REQ-028 SHALL, with the macro defined, on accept in IDLE with a==0 or b==0, skip BUSY: load c=0, set out_valid=1, enter DONE; latency 1 edge.
REQ-029 SHALL, without the macro, run all D*D BUSY cycles for every operand pair, including zero operands.

Verification
REQ-030 SHALL cover: N=4, a=3, b=3, out_ready=1 -> in_ready low 5 cycles, out_valid high exactly 1 cycle, 5 edges after accept, c=9.
REQ-031 SHALL cover: N=4, a=15, b=15 -> c=225; then back-to-back a=10, b=6 accepted the cycle after the handshake -> c=60.
REQ-032 SHALL cover: N=4, a=7, b=9, out_ready held 0 for 3 cycles after out_valid -> c=63 and out_valid stable all 3 cycles; in_valid pulses with a=1, b=1 during BUSY/DONE do not alter c.
REQ-033 SHALL cover: N=4, a=12, b=5, rst=1 on second BUSY cycle -> next cycle out_valid=0, c=0, in_ready=1; new a=2, b=3 -> c=6.
REQ-034 SHALL cover: N=4, a=0, b=13 -> c=0 with out_valid 1 edge after accept if DIGIT_SERIAL_MUL_ZERO_BYPASS_EN is defined, 5 edges if it is not.
REQ-035 SHALL cover: N=8, a=255, b=255 -> c=65025 with out_valid 17 edges after accept.
